imm_packer: RTL and testbench

//  Inverse of the decode-stage immediate extender. Takes a base instruction word
//  (opcode/register fields already set), a 32-bit immediate and the ARM/RISC-V

---
 rtl/imm_packer.sv | 169 ++++++++++++++++
 tb/tb_imm_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// Immediate packer: inserts a 32-bit immediate into RISC-V / ARM instruction fields and flags unencodable values.
// Latency: 1 cycle from input handshake to out_valid when the 2-entry buffer is empty.
// Backpressure: in_ready drops only when both buffer entries are held; it never depends combinationally on out_ready.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign wr_rdy  = (count != CW'(DEPTH));
  assign rd_vld  = (count != '0);
  assign do_push = wr_vld && wr_rdy;
  assign do_pop  = rd_vld && rd_rdy;
  assign rd_dat  = mem[rd_ptr];

  // Storage and pointers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

module imm_packer #(
  parameter bit SUPPORT_ARM   = 1'b1,
  parameter bit SUPPORT_RISCV = 1'b1,
  parameter int ERRCNT_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_arm,
  input  logic [1:0]          in_immsrc,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_base,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic                out_err,
  input  logic                err_clr,
  output logic [ERRCNT_W-1:0] err_count
);
  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  entry_t      enc;
  entry_t      head;
  logic        arm_sel;
  logic        ok;
  logic [31:0] packed_w;

  // True when v sign-extends from its low n bits (v[31:n-1] all zeros or all ones).
  function automatic logic fits_signed(input logic [31:0] v, input int n);
    logic signed [31:0] t;
    t = $signed(v) >>> (n - 1);
    return (t == '0) || (t == '1);
  endfunction

  // An absent ISA family forces the select toward the one that is built in.
  assign arm_sel = SUPPORT_ARM ? (SUPPORT_RISCV ? in_arm : 1'b1) : 1'b0;

  // Field insertion and representability check; failing items pass the base word through.
  always_comb begin
    ok       = 1'b0;
    packed_w = in_base;
    if (arm_sel) begin
      case (in_immsrc)
        2'b00: begin
          ok       = (in_imm[31:8] == 24'd0);
          packed_w = {in_base[31:8], in_imm[7:0]};
        end
        2'b01: begin
          ok       = (in_imm[31:12] == 20'd0);
          packed_w = {in_base[31:12], in_imm[11:0]};
        end
        2'b10: begin
          ok       = fits_signed(in_imm, 26) && (in_imm[1:0] == 2'b00);
          packed_w = {in_base[31:24], in_imm[25:2]};
        end
        2'b11: begin
          ok       = 1'b0;
          packed_w = in_base;
        end
      endcase
    end else begin
      case (in_immsrc)
        2'b00: begin
          ok       = fits_signed(in_imm, 12);
          packed_w = {in_imm[11:0], in_base[19:0]};
        end
        2'b01: begin
          ok       = fits_signed(in_imm, 12);
          packed_w = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
        end
        2'b10: begin
          ok       = fits_signed(in_imm, 13) && !in_imm[0];
          packed_w = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1], in_imm[11], in_base[6:0]};
        end
        2'b11: begin
          ok       = fits_signed(in_imm, 21) && !in_imm[0];
          packed_w = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_base[11:0]};
        end
      endcase
    end
    enc.err   = !ok;
    enc.instr = ok ? packed_w : in_base;
  end

  sync_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (2)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (enc),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (head)
  );

  assign out_instr = head.instr;
  assign out_err   = head.err;

  // Saturating count of erroring items leaving the block; clear wins over a same-cycle error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_packer.sv
// Self-checking bench for imm_packer: scoreboard of expected words, stall/order, error counter, reset.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A monitor process pops the scoreboard on every output handshake it sees.

module tb_imm_packer;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_arm;
  logic [1:0]    in_immsrc;
  logic [31:0]   in_imm;
  logic [31:0]   in_base;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic          err_clr;
  logic [CW-1:0] err_count;

  int          checks   = 0;
  int          failures = 0;
  logic [32:0] sb[$];
  logic [31:0] exp_cnt  = 0;

  imm_packer #(
    .SUPPORT_ARM   (1'b1),
    .SUPPORT_RISCV (1'b1),
    .ERRCNT_W      (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_arm    (in_arm),
    .in_immsrc (in_immsrc),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one item; the expected result joins the scoreboard when it is accepted.
  task automatic send(input logic arm, input logic [1:0] src, input logic [31:0] imm,
                      input logic [31:0] base, input logic [31:0] exp_instr, input logic exp_err);
    logic done;
    done      = 1'b0;
    in_arm    = arm;
    in_immsrc = src;
    in_imm    = imm;
    in_base   = base;
    in_valid  = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (in_ready) begin
        sb.push_back({exp_err, exp_instr});
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares each emitted item against the scoreboard and tracks the error count.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("err_count", 32'(err_count), exp_cnt);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", out_instr, 32'hDEADBEEF);
            e = 33'd0;
          end else begin
            e = sb.pop_front();
            chk("out_instr", out_instr, e[31:0]);
            chk("out_err", {31'd0, out_err}, {31'd0, e[32]});
          end
          if (!err_clr && e[32] && exp_cnt < 3) exp_cnt = exp_cnt + 1;
        end
        if (err_clr) exp_cnt = 0;
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_arm    = 1'b0;
    in_immsrc = 2'b00;
    in_imm    = '0;
    in_base   = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // RISC-V I and B
    send(1'b0, 2'b00, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0);
    send(1'b0, 2'b00, 32'h00000800, 32'h00000013, 32'h00000013, 1'b1);
    send(1'b0, 2'b10, 32'h00000010, 32'h00000063, 32'h00000863, 1'b0);
    send(1'b0, 2'b10, 32'h00000011, 32'h00000063, 32'h00000063, 1'b1);
    drain();
    chk("errcnt_after_rv", 32'(err_count), 32'd2);

    // RISC-V J and S, ARM 00/01/11
    send(1'b0, 2'b11, 32'h00000800, 32'h0000006F, 32'h0010006F, 1'b0);
    send(1'b0, 2'b01, 32'hFFFFFFFC, 32'h00002023, 32'hFE002E23, 1'b0);
    send(1'b1, 2'b00, 32'h00000100, 32'hE3A00000, 32'hE3A00000, 1'b1);
    send(1'b1, 2'b00, 32'h000000FF, 32'hE3A00000, 32'hE3A000FF, 1'b0);
    send(1'b1, 2'b01, 32'h00000FFF, 32'hE5900000, 32'hE5900FFF, 1'b0);
    send(1'b1, 2'b11, 32'h00000000, 32'hE3A00000, 32'hE3A00000, 1'b1);

    // ARM branch
    send(1'b1, 2'b10, 32'hFFFFFFF8, 32'hEA000000, 32'hEAFFFFFE, 1'b0);
    send(1'b1, 2'b10, 32'h02000000, 32'hEA000000, 32'hEA000000, 1'b1);
    send(1'b1, 2'b10, 32'h00000006, 32'hEA000000, 32'hEA000000, 1'b1);
    drain();

    // Stall: A and B fill the buffer, C waits at the input, then all three drain in order
    out_ready = 1'b0;
    send(1'b0, 2'b00, 32'h00000001, 32'h00000013, 32'h00100013, 1'b0);
    send(1'b0, 2'b00, 32'h00000002, 32'h00000013, 32'h00200013, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    fork
      send(1'b0, 2'b00, 32'h00000003, 32'h00000013, 32'h00300013, 1'b0);
      begin
        tick();
        tick();
        chk("c_held_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_head_hold", out_instr, 32'h00100013);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("back2back_valid", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    drain();

    // Error counter: clear, saturate, clear against a concurrent erroring pop
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("errcnt_cleared", 32'(err_count), 32'd0);
    for (int i = 0; i < 5; i++)
      send(1'b1, 2'b11, 32'(i), 32'hE0000000, 32'hE0000000, 1'b1);
    drain();
    chk("errcnt_saturated", 32'(err_count), 32'd3);
    out_ready = 1'b0;
    send(1'b1, 2'b11, 32'h00000000, 32'hE1000000, 32'hE1000000, 1'b1);
    tick();
    err_clr   = 1'b1;
    out_ready = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("errcnt_clr_prio", 32'(err_count), 32'd0);
    drain();

    // Reset while two items are held
    out_ready = 1'b0;
    send(1'b1, 2'b11, 32'h00000000, 32'hE2000000, 32'hE2000000, 1'b1);
    send(1'b0, 2'b00, 32'h00000005, 32'h00000013, 32'h00500013, 1'b0);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_instr", out_instr, 32'd0);
    chk("mid_rst_out_err", {31'd0, out_err}, 32'd0);
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    send(1'b0, 2'b11, 32'hFFFFF000, 32'h000000EF, 32'h800FF0EF, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
